// File: rtl/mcu_spi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_pkg
// Purpose  : Shared types and default constants for the MCU SPI source arbiter.
// Revision : 1.0
// ============================================================================
package mcu_pkg;

    typedef enum logic [1:0] {
        INT    = 2'd0,
        SW_EXT = 2'd1,
        EXT    = 2'd2,
        SW_INT = 2'd3
    } arb_state_t;

    localparam int ARB_DEBOUNCE = 4;
    localparam int ARB_GUARD    = 2;
    localparam int ARB_TIMEOUT  = 0;
    localparam int ARB_TO_W     = 24;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_spi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mcu_spi_arbiter_if
// Purpose  : Board-side SPI pins of both MCU sources plus the core-side result.
// Revision : 1.0
// ============================================================================
interface mcu_spi_arbiter_if;

    logic       int_sclk;
    logic       int_csn;
    logic       int_mosi;
    logic       ext_sclk;
    logic       ext_csn;
    logic       ext_mosi;
    logic       core_sclk;
    logic       core_csn;
    logic       core_mosi;
    logic       sel_ext;
    logic       switching;
    logic [7:0] coll_cnt;

    // Board / test side: drives both SPI sources, observes the core side.
    modport master (
        output int_sclk, int_csn, int_mosi,
        output ext_sclk, ext_csn, ext_mosi,
        input  core_sclk, core_csn, core_mosi,
        input  sel_ext, switching, coll_cnt
    );

    // Arbiter side.
    modport slave (
        input  int_sclk, int_csn, int_mosi,
        input  ext_sclk, ext_csn, ext_mosi,
        output core_sclk, core_csn, core_mosi,
        output sel_ext, switching, coll_cnt
    );

endinterface
`default_nettype wire

// File: rtl/mcu_spi_arbiter_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer with a selectable reset value.
// Revision : 1.0
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta_q;
    logic r_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= RESET_VAL;
            r_sync_q <= RESET_VAL;
        end else begin
            r_meta_q <= i_d;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_q = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/mcu_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mcu_spi_arbiter
// Purpose  : Frame-safe selection between the internal and external MCU SPI
//            masters, with debounce, guard gap, optional revert and collisions.
// Revision : 1.0
// ============================================================================
module mcu_spi_arbiter
    import mcu_pkg::*;
#(
    parameter int DEBOUNCE = ARB_DEBOUNCE,
    parameter int GUARD    = ARB_GUARD,
    parameter int TIMEOUT  = ARB_TIMEOUT,
    parameter int TO_W     = ARB_TO_W
) (
    input  wire logic         clk32,
    input  wire logic         por,
    mcu_spi_arbiter_if.slave  arb
);

    localparam logic [7:0]      C_DEB_MAX    = 8'(DEBOUNCE);
    localparam logic [3:0]      C_GUARD_LAST = 4'(GUARD - 1);
    localparam logic [TO_W-1:0] C_TO_MAX     = TO_W'(TIMEOUT);
    localparam logic            C_REVERT_EN  = (TIMEOUT != 0);

    logic w_int_cs_s;
    logic w_ext_cs_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync_int (
        .clk (clk32),
        .rst (por),
        .i_d (arb.int_csn),
        .o_q (w_int_cs_s)
    );

    sync2 #(.RESET_VAL(1'b1)) u_sync_ext (
        .clk (clk32),
        .rst (por),
        .i_d (arb.ext_csn),
        .o_q (w_ext_cs_s)
    );

    arb_state_t      r_state_q,       w_state_d;
    logic [7:0]      r_deb_q,         w_deb_d;
    logic [TO_W-1:0] r_to_q,          w_to_d;
    logic [3:0]      r_guard_q,       w_guard_d;
    logic [7:0]      r_coll_q,        w_coll_d;
    logic            r_int_cs_prev_q;
    logic            r_sel_ext_q,     w_sel_ext_d;
    logic            r_switching_q,   w_switching_d;
    logic            w_int_fall;

    always_comb begin
        w_state_d  = r_state_q;
        w_guard_d  = r_guard_q;
        w_to_d     = '0;
        w_int_fall = r_int_cs_prev_q & ~w_int_cs_s;

        if (w_ext_cs_s) begin
            w_deb_d = '0;
        end else if (r_deb_q == C_DEB_MAX) begin
            w_deb_d = r_deb_q;
        end else begin
            w_deb_d = r_deb_q + 8'd1;
        end

        if ((r_state_q != INT) && w_int_fall) begin
            w_coll_d = sat_inc8(r_coll_q);
        end else begin
            w_coll_d = r_coll_q;
        end

        case (r_state_q)
            INT: begin
                // Debounce completing on this cycle's sample; a busy internal
                // frame (including one that just started) always wins.
                if ((w_deb_d == C_DEB_MAX) && w_int_cs_s) begin
                    w_state_d = SW_EXT;
                    w_guard_d = '0;
                end
            end
            SW_EXT: begin
                if (r_guard_q == C_GUARD_LAST) begin
                    w_state_d = EXT;
                    w_guard_d = '0;
                end else begin
                    w_guard_d = r_guard_q + 4'd1;
                end
            end
            EXT: begin
                if (w_ext_cs_s) begin
                    w_to_d = (r_to_q == C_TO_MAX) ? r_to_q : r_to_q + 1'b1;
                end
                // A falling ext CSN on the revert cycle keeps the external link.
                if (C_REVERT_EN && (r_to_q == C_TO_MAX) && w_ext_cs_s && w_int_cs_s) begin
                    w_state_d = SW_INT;
                    w_guard_d = '0;
                end
            end
            SW_INT: begin
                if (r_guard_q == C_GUARD_LAST) begin
                    w_state_d = INT;
                    w_guard_d = '0;
                    w_deb_d   = '0;
                end else begin
                    w_guard_d = r_guard_q + 4'd1;
                end
            end
            default: begin
                w_state_d = INT;
                w_guard_d = '0;
            end
        endcase

        w_sel_ext_d   = (w_state_d == EXT)    || (w_state_d == SW_INT);
        w_switching_d = (w_state_d == SW_EXT) || (w_state_d == SW_INT);
    end

    always_ff @(posedge clk32) begin
        if (por) begin
            r_state_q       <= INT;
            r_deb_q         <= '0;
            r_to_q          <= '0;
            r_guard_q       <= '0;
            r_coll_q        <= '0;
            r_int_cs_prev_q <= 1'b1;
            r_sel_ext_q     <= 1'b0;
            r_switching_q   <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_deb_q         <= w_deb_d;
            r_to_q          <= w_to_d;
            r_guard_q       <= w_guard_d;
            r_coll_q        <= w_coll_d;
            r_int_cs_prev_q <= w_int_cs_s;
            r_sel_ext_q     <= w_sel_ext_d;
            r_switching_q   <= w_switching_d;
        end
    end

    // Pin-level path: no clk32 latency, CSN gated high through the guard gap.
    assign arb.core_sclk = r_sel_ext_q ? arb.ext_sclk : arb.int_sclk;
    assign arb.core_mosi = r_sel_ext_q ? arb.ext_mosi : arb.int_mosi;
    assign arb.core_csn  = r_switching_q | (r_sel_ext_q ? arb.ext_csn : arb.int_csn);
    assign arb.sel_ext   = r_sel_ext_q;
    assign arb.switching = r_switching_q;
    assign arb.coll_cnt  = r_coll_q;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_spi_arbiter
// Purpose  : Directed bench; dut_a is sticky (TIMEOUT=0), dut_b reverts (100).
// Revision : 1.0
// ============================================================================
module tb_mcu_spi_arbiter;

    logic clk32 = 1'b0;
    logic por;
    logic int_sclk, int_csn, int_mosi;
    logic ext_sclk, ext_csn, ext_mosi;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [15:0] pat = 16'hA5C3;

    always #5 clk32 = ~clk32;

    mcu_spi_arbiter_if ifa ();
    mcu_spi_arbiter_if ifb ();

    assign ifa.int_sclk = int_sclk;
    assign ifa.int_csn  = int_csn;
    assign ifa.int_mosi = int_mosi;
    assign ifa.ext_sclk = ext_sclk;
    assign ifa.ext_csn  = ext_csn;
    assign ifa.ext_mosi = ext_mosi;
    assign ifb.int_sclk = int_sclk;
    assign ifb.int_csn  = int_csn;
    assign ifb.int_mosi = int_mosi;
    assign ifb.ext_sclk = ext_sclk;
    assign ifb.ext_csn  = ext_csn;
    assign ifb.ext_mosi = ext_mosi;

    mcu_spi_arbiter #(.DEBOUNCE(4), .GUARD(2), .TIMEOUT(0), .TO_W(24)) dut_a (
        .clk32 (clk32),
        .por   (por),
        .arb   (ifa.slave)
    );

    mcu_spi_arbiter #(.DEBOUNCE(4), .GUARD(2), .TIMEOUT(100), .TO_W(24)) dut_b (
        .clk32 (clk32),
        .por   (por),
        .arb   (ifb.slave)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk32);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_int();
        int_csn = 1'b0;
        tick(2);
        int_csn = 1'b1;
        tick(2);
    endtask

    initial begin
        por = 1'b1;
        int_sclk = 1'b0; int_csn = 1'b1; int_mosi = 1'b0;
        ext_sclk = 1'b0; ext_csn = 1'b1; ext_mosi = 1'b0;
        tick(3);
        chk1("rst_sel_a",  ifa.sel_ext,   1'b0);
        chk1("rst_sw_a",   ifa.switching, 1'b0);
        chk8("rst_coll_a", ifa.coll_cnt,  8'd0);
        chk1("rst_csn_a",  ifa.core_csn,  1'b1);
        chk1("rst_sel_b",  ifb.sel_ext,   1'b0);
        por = 1'b0;
        tick(1);

        // Internal frame, ext idle: core mirrors int
        int_csn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            int_sclk = i[0];
            int_mosi = pat[i / 2];
            ext_sclk = ~i[0];
            ext_mosi = ~pat[i / 2];
            #1;
            chk1("t1_sclk", ifa.core_sclk, int_sclk);
            chk1("t1_mosi", ifa.core_mosi, int_mosi);
            chk1("t1_csn",  ifa.core_csn,  1'b0);
            chk1("t1_sel",  ifa.sel_ext,   1'b0);
            tick(1);
        end
        int_csn = 1'b1; int_sclk = 1'b0; ext_sclk = 1'b0; ext_mosi = 1'b0;
        tick(4);
        chk8("t1_coll", ifa.coll_cnt, 8'd0);
        chk1("t1_csn_idle", ifa.core_csn, 1'b1);

        // ext_csn low at T with int idle: guard T+6..T+7, selected from T+8
        ext_csn = 1'b0;
        tick(5);
        chk1("t2_sw_T5",  ifa.switching, 1'b0);
        chk1("t2_sel_T5", ifa.sel_ext,   1'b0);
        tick(1);
        chk1("t2_sw_T6",  ifa.switching, 1'b1);
        chk1("t2_sel_T6", ifa.sel_ext,   1'b0);
        chk1("t2_csn_T6", ifa.core_csn,  1'b1);
        tick(1);
        chk1("t2_sw_T7",  ifa.switching, 1'b1);
        chk1("t2_csn_T7", ifa.core_csn,  1'b1);
        tick(1);
        chk1("t2_sel_T8",  ifa.sel_ext,   1'b1);
        chk1("t2_sw_T8",   ifa.switching, 1'b0);
        chk1("t2_csn_T8",  ifa.core_csn,  1'b0);
        chk1("t2_sel_b",   ifb.sel_ext,   1'b1);
        ext_sclk = 1'b1; ext_mosi = 1'b1;
        #1;
        chk1("t2_sclk_ext1", ifa.core_sclk, 1'b1);
        chk1("t2_mosi_ext1", ifa.core_mosi, 1'b1);
        ext_sclk = 1'b0; int_sclk = 1'b1; int_mosi = 1'b1;
        #1;
        chk1("t2_sclk_ext0", ifa.core_sclk, 1'b0);
        chk1("t2_mosi_ext0", ifa.core_mosi, 1'b1);
        int_sclk = 1'b0; int_mosi = 1'b0; ext_mosi = 1'b0;
        tick(1);

        // Collisions while external is selected
        for (int i = 0; i < 3; i++) pulse_int();
        tick(3);
        chk8("t4_coll3_a", ifa.coll_cnt, 8'd3);
        chk8("t4_coll3_b", ifb.coll_cnt, 8'd3);
        chk1("t4_csn_ext", ifa.core_csn, 1'b0);
        for (int i = 0; i < 251; i++) pulse_int();
        tick(3);
        chk8("t4_coll254", ifa.coll_cnt, 8'd254);
        for (int i = 0; i < 49; i++) pulse_int();
        tick(3);
        chk8("t4_coll255_a", ifa.coll_cnt, 8'd255);
        chk8("t4_coll255_b", ifb.coll_cnt, 8'd255);
        chk1("t4_sel_a",     ifa.sel_ext,  1'b1);

        // Revert timeout: 99 high cycles is not enough
        ext_csn = 1'b1;
        tick(99);
        ext_csn = 1'b0;
        tick(10);
        chk1("t5_hold_sel_b", ifb.sel_ext,   1'b1);
        chk1("t5_hold_sw_b",  ifb.switching, 1'b0);
        chk1("t5_hold_sel_a", ifa.sel_ext,   1'b1);
        ext_csn = 1'b1;
        tick(102);
        chk1("t5_pre_sw_b",  ifb.switching, 1'b0);
        chk1("t5_pre_sel_b", ifb.sel_ext,   1'b1);
        tick(1);
        chk1("t5_sw1_b",  ifb.switching, 1'b1);
        chk1("t5_sel1_b", ifb.sel_ext,   1'b1);
        chk1("t5_csn1_b", ifb.core_csn,  1'b1);
        tick(1);
        chk1("t5_sw2_b",  ifb.switching, 1'b1);
        tick(1);
        chk1("t5_sel_b",    ifb.sel_ext,   1'b0);
        chk1("t5_sw_b",     ifb.switching, 1'b0);
        chk1("t5_sticky_a", ifa.sel_ext,   1'b1);
        chk1("t5_sw_a",     ifa.switching, 1'b0);
        chk8("t5_coll_b",   ifb.coll_cnt,  8'd255);
        int_sclk = 1'b1;
        #1;
        chk1("t5_sclk_b", ifb.core_sclk, 1'b1);
        chk1("t5_sclk_a", ifa.core_sclk, 1'b0);
        int_sclk = 1'b0;
        tick(1);

        // Reset clears everything including the saturated collision count
        por = 1'b1;
        tick(1);
        chk1("t3_rst_sel_a",  ifa.sel_ext,  1'b0);
        chk8("t3_rst_coll_a", ifa.coll_cnt, 8'd0);
        chk1("t3_rst_csn_a",  ifa.core_csn, 1'b1);
        por = 1'b0;
        tick(3);

        // ext requests during a 40-cycle int frame: frame is never cut
        int_csn = 1'b0;
        tick(3);
        ext_csn = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick(1);
            chk1("t3_frame_csn", ifa.core_csn,  1'b0);
            chk1("t3_frame_sw",  ifa.switching, 1'b0);
        end
        int_csn = 1'b1;
        tick(2);
        chk1("t3_idle_sw",  ifa.switching, 1'b0);
        chk1("t3_idle_csn", ifa.core_csn,  1'b1);
        tick(1);
        chk1("t3_sw1",  ifa.switching, 1'b1);
        chk1("t3_sel1", ifa.sel_ext,   1'b0);
        tick(1);
        chk1("t3_sw2",  ifa.switching, 1'b1);
        tick(1);
        chk1("t3_sel",  ifa.sel_ext,   1'b1);
        chk1("t3_csn",  ifa.core_csn,  1'b0);
        chk8("t3_coll", ifa.coll_cnt,  8'd0);

        // por during SW_EXT with ext_csn held low
        por = 1'b1;
        tick(1);
        por = 1'b0;
        chk1("t6_rst_sel", ifa.sel_ext, 1'b0);
        tick(5);
        chk1("t6_pre_sw", ifa.switching, 1'b0);
        tick(1);
        chk1("t6_in_sw",  ifa.switching, 1'b1);
        por = 1'b1;
        tick(1);
        chk1("t6_abort_sel", ifa.sel_ext,   1'b0);
        chk1("t6_abort_sw",  ifa.switching, 1'b0);
        chk1("t6_abort_csn", ifa.core_csn,  1'b1);
        chk8("t6_abort_coll", ifa.coll_cnt, 8'd0);
        por = 1'b0;
        tick(5);
        chk1("t6_re_pre_sw", ifa.switching, 1'b0);
        tick(1);
        chk1("t6_re_sw1", ifa.switching, 1'b1);
        tick(1);
        chk1("t6_re_sw2", ifa.switching, 1'b1);
        chk1("t6_re_sel0", ifa.sel_ext,  1'b0);
        tick(1);
        chk1("t6_re_sel", ifa.sel_ext,   1'b1);
        chk1("t6_re_csn", ifa.core_csn,  1'b0);

        if (n_fail != 0) $display("%0d checks did not match", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
